vec_switch: RTL

VEC_SWITCH -- requirements
Module: vec_switch

---
 rtl/vec_switch.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/vec_switch.sv
// Mailbox crossbar between vector cores: one single-entry mailbox per (src,dst)
// pair, handshaked per core by a send FSM and a recv FSM. Lanes are IEEE-754 single bit patterns.
module vec_switch_port #(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int AW = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   send_ready,
  input  logic [AW-1:0]          send_core_idx,
  input  logic                   recv_request,
  input  logic [AW-1:0]          recv_core_idx,
  input  logic [N-1:0]           row_full,
  input  logic [N-1:0]           col_full,
  input  logic [N-1:0][W-1:0][31:0] col_data,
  output logic                   send_ok,
  output logic [N-1:0]           send_wr,
  output logic                   recv_ready,
  output logic [N-1:0]           recv_take,
  output logic [W-1:0][31:0]     recv_data,
  output logic                   fsm_idle
);
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} send_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_HOLD} recv_state_e;

  send_state_e          send_state_q, send_state_d;
  recv_state_e          recv_state_q, recv_state_d;
  logic [W-1:0][31:0]   recv_data_q, recv_data_d;

  // An out-of-range index matches no mailbox, so it is never accepted.
  always_comb begin
    send_state_d = send_state_q;
    send_wr      = '0;
    case (send_state_q)
      S_IDLE: begin
        if (send_ready) begin
          for (int d = 0; d < N; d++) begin
            if (send_core_idx == AW'(d) && !row_full[d]) begin
              send_wr[d]   = 1'b1;
              send_state_d = S_ACK;
            end
          end
        end
      end
      S_ACK:   send_state_d = send_ready ? S_HOLD : S_IDLE;
      S_HOLD:  if (!send_ready) send_state_d = S_IDLE;
      default: send_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    recv_state_d = recv_state_q;
    recv_data_d  = recv_data_q;
    recv_take    = '0;
    case (recv_state_q)
      R_IDLE: begin
        if (recv_request) begin
          for (int s = 0; s < N; s++) begin
            if (recv_core_idx == AW'(s) && col_full[s]) begin
              recv_take[s] = 1'b1;
              recv_data_d  = col_data[s];
              recv_state_d = R_ACK;
            end
          end
        end
      end
      R_ACK:   recv_state_d = recv_request ? R_HOLD : R_IDLE;
      R_HOLD:  if (!recv_request) recv_state_d = R_IDLE;
      default: recv_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      send_state_q <= S_IDLE;
      recv_state_q <= R_IDLE;
      recv_data_q  <= '0;
    end else begin
      send_state_q <= send_state_d;
      recv_state_q <= recv_state_d;
      recv_data_q  <= recv_data_d;
    end
  end

  assign send_ok    = (send_state_q == S_ACK);
  assign recv_ready = (recv_state_q == R_ACK);
  assign recv_data  = recv_data_q;
  assign fsm_idle   = (send_state_d == S_IDLE) && (recv_state_d == R_IDLE);
endmodule

module vec_switch #(
  parameter int SWITCH_CORE_SIZE      = 4,
  parameter int SWITCH_WIDTH          = 16,
  parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic [SWITCH_CORE_SIZE-1:0]                         send_ready,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] send_core_idx,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0] send_data,
  output logic [SWITCH_CORE_SIZE-1:0]                         send_ok,
  input  logic [SWITCH_CORE_SIZE-1:0]                         recv_request,
  input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] recv_core_idx,
  output logic [SWITCH_CORE_SIZE-1:0]                         recv_ready,
  output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][31:0] recv_data,
  output logic                                                idle
);
  localparam int N  = SWITCH_CORE_SIZE;
  localparam int W  = SWITCH_WIDTH;
  localparam int AW = SWITCH_CORE_ADDR_SIZE;

  // Mailboxes indexed [src][dst]; the *_t copies are [dst][src] for the recv side.
  logic [N-1:0][N-1:0]              full_q, full_d, full_t;
  logic [N-1:0][N-1:0][W-1:0][31:0] data_q, data_d, data_t;
  logic [N-1:0][N-1:0]              wr;    // [src][dst]
  logic [N-1:0][N-1:0]              take;  // [dst][src]
  logic [N-1:0]                     port_idle;
  logic                             idle_q, idle_d;

  for (genvar c = 0; c < N; c++) begin : g_port
    vec_switch_port #(.N(N), .W(W), .AW(AW)) u_port (
      .clock         (clock),
      .reset         (reset),
      .send_ready    (send_ready[c]),
      .send_core_idx (send_core_idx[c]),
      .recv_request  (recv_request[c]),
      .recv_core_idx (recv_core_idx[c]),
      .row_full      (full_q[c]),
      .col_full      (full_t[c]),
      .col_data      (data_t[c]),
      .send_ok       (send_ok[c]),
      .send_wr       (wr[c]),
      .recv_ready    (recv_ready[c]),
      .recv_take     (take[c]),
      .recv_data     (recv_data[c]),
      .fsm_idle      (port_idle[c])
    );
  end

  always_comb begin
    full_t = '0;
    data_t = '0;
    for (int s = 0; s < N; s++) begin
      for (int d = 0; d < N; d++) begin
        full_t[d][s] = full_q[s][d];
        data_t[d][s] = data_q[s][d];
      end
    end
  end

  // A take needs full and a write needs empty at cycle start, so they never collide.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    for (int s = 0; s < N; s++) begin
      for (int d = 0; d < N; d++) begin
        if (take[d][s]) full_d[s][d] = 1'b0;
        if (wr[s][d]) begin
          full_d[s][d] = 1'b1;
          data_d[s][d] = send_data[s];
        end
      end
    end
    idle_d = ~|full_d && &port_idle;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q <= '0;
      idle_q <= 1'b0;
    end else begin
      full_q <= full_d;
      idle_q <= idle_d;
    end
  end

  always_ff @(posedge clock) data_q <= data_d;

  assign idle = idle_q;
endmodule
